disco_setorizado: RTL



---
 rtl/disco_setorizado.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/disco_setorizado.sv
// disco_setorizado: sector-organised block storage with a modelled seek
// latency. Whole sectors move through a command handshake plus valid/ready
// read and write streams. Storage is not touched by reset.
module disco_setorizado #(
  parameter int DATA_W       = 32,
  parameter int SECTOR_WORDS = 16,
  parameter int NUM_SECTORS  = 64,
  parameter int SEEK_CYCLES  = 4,
  parameter int SEC_W        = $clog2(NUM_SECTORS) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [SEC_W-1:0]  cmd_sector,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int IDX_W  = $clog2(SECTOR_WORDS);
  localparam int SIDX_W = SEC_W - 1;
  localparam int ADDR_W = SIDX_W + IDX_W;
  localparam int DEPTH  = NUM_SECTORS * SECTOR_WORDS;
  localparam int SK_W   = (SEEK_CYCLES > 1) ? $clog2(SEEK_CYCLES) : 1;

  localparam logic [SK_W-1:0]  SEEK_LOAD = SK_W'(SEEK_CYCLES - 1);
  localparam logic [SEC_W-1:0] SEC_LIMIT = SEC_W'(NUM_SECTORS);

  if (SECTOR_WORDS < 2 || (SECTOR_WORDS & (SECTOR_WORDS - 1)) != 0) begin : g_bad_sw
    $error("SECTOR_WORDS must be a power of two and at least 2");
  end
  if (NUM_SECTORS < 2) begin : g_bad_ns
    $error("NUM_SECTORS must be at least 2");
  end
  if (SEEK_CYCLES < 1) begin : g_bad_seek
    $error("SEEK_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEEK,
    S_XFER_RD,
    S_XFER_WR,
    S_DONE
  } state_t;

  state_t             r_state;
  logic               r_write;
  logic [SEC_W-1:0]   r_sector;
  logic [IDX_W-1:0]   r_idx;
  logic [SK_W-1:0]    r_seek;
  logic [SEC_W-1:0]   r_head;
  logic               r_head_ok;
  logic               r_err;

  state_t             w_state_nx;
  logic               w_write_nx;
  logic [SEC_W-1:0]   w_sector_nx;
  logic [IDX_W-1:0]   w_idx_nx;
  logic [SK_W-1:0]    w_seek_nx;
  logic [SEC_W-1:0]   w_head_nx;
  logic               w_head_ok_nx;
  logic               w_err_nx;

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0]  w_addr;
  logic               w_idx_last;
  logic               w_wr_hs;
  logic [DATA_W-1:0]  w_rd_word;

  // Sector-major addressing: sector s, word i sits at s*SECTOR_WORDS+i.
  assign w_addr     = {r_sector[SIDX_W-1:0], r_idx};
  assign w_idx_last = (r_idx == '1);
  assign w_wr_hs    = (r_state == S_XFER_WR) && wr_valid;
  assign w_rd_word  = r_mem[w_addr];

  // Control state register and command/head bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_write   <= 1'b0;
      r_sector  <= '0;
      r_idx     <= '0;
      r_seek    <= '0;
      r_head    <= '0;
      r_head_ok <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_write   <= w_write_nx;
      r_sector  <= w_sector_nx;
      r_idx     <= w_idx_nx;
      r_seek    <= w_seek_nx;
      r_head    <= w_head_nx;
      r_head_ok <= w_head_ok_nx;
      r_err     <= w_err_nx;
    end
  end

  // Sector storage; deliberately outside reset so aborted writes persist.
  always_ff @(posedge clk) begin
    if (w_wr_hs) begin
      r_mem[w_addr] <= wr_data;
    end
  end

  // Next-state logic: command decode, seek countdown, transfer stepping.
  always_comb begin
    w_state_nx   = r_state;
    w_write_nx   = r_write;
    w_sector_nx  = r_sector;
    w_idx_nx     = r_idx;
    w_seek_nx    = r_seek;
    w_head_nx    = r_head;
    w_head_ok_nx = r_head_ok;
    w_err_nx     = r_err;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_write_nx  = cmd_write;
          w_sector_nx = cmd_sector;
          w_idx_nx    = '0;
          if (cmd_sector >= SEC_LIMIT) begin
            w_err_nx   = 1'b1;
            w_state_nx = S_DONE;
          end else if (r_head_ok && (cmd_sector == r_head)) begin
            w_state_nx = cmd_write ? S_XFER_WR : S_XFER_RD;
          end else begin
            w_seek_nx  = SEEK_LOAD;
            w_state_nx = S_SEEK;
          end
        end
      end
      S_SEEK: begin
        if (r_seek == '0) begin
          w_head_nx    = r_sector;
          w_head_ok_nx = 1'b1;
          w_state_nx   = r_write ? S_XFER_WR : S_XFER_RD;
        end else begin
          w_seek_nx = r_seek - SK_W'(1);
        end
      end
      S_XFER_WR: begin
        if (wr_valid) begin
          w_idx_nx = r_idx + IDX_W'(1);
          if (w_idx_last) begin
            w_state_nx = S_DONE;
          end
        end
      end
      S_XFER_RD: begin
        if (rd_ready) begin
          w_idx_nx = r_idx + IDX_W'(1);
          if (w_idx_last) begin
            w_state_nx = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_err_nx   = 1'b0;
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Status and stream outputs are pure decodes of the current state.
  always_comb begin
    cmd_ready = (r_state == S_IDLE);
    busy      = (r_state != S_IDLE);
    wr_ready  = (r_state == S_XFER_WR);
    rd_valid  = (r_state == S_XFER_RD);
    rd_last   = (r_state == S_XFER_RD) && w_idx_last;
    done      = (r_state == S_DONE);
    err       = (r_state == S_DONE) && r_err;
    rd_data   = (r_state == S_XFER_RD) ? w_rd_word : '0;
  end

endmodule
